// File: rtl/univ_reg.sv
// Universal register: parallel load, serial shift, rotate and up/down count with
// registered serial-out and carry flags plus a combinational zero flag.
module univ_reg #(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             carry,
    output logic             zero
);

    localparam logic [2:0] ModeHold = 3'b000;
    localparam logic [2:0] ModeLoad = 3'b001;
    localparam logic [2:0] ModeShl  = 3'b010;
    localparam logic [2:0] ModeShr  = 3'b011;
    localparam logic [2:0] ModeRotl = 3'b100;
    localparam logic [2:0] ModeRotr = 3'b101;
    localparam logic [2:0] ModeInc  = 3'b110;
    localparam logic [2:0] ModeDec  = 3'b111;

    localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] AllZero = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};

    if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
        $error("univ_reg: WIDTH must be in 2..64");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             carry_q, carry_d;

    always_comb begin
        q_d     = q_q;
        sout_d  = sout_q;
        carry_d = carry_q;
        if (en) begin
            case (mode)
                ModeHold: ;
                ModeLoad: begin
                    q_d     = d;
                    carry_d = 1'b0;
                end
                ModeShl: begin
                    q_d    = {q_q[WIDTH-2:0], sin_l};
                    sout_d = q_q[WIDTH-1];
                end
                ModeShr: begin
                    q_d    = {sin_r, q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                ModeRotl: begin
                    q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    sout_d = q_q[WIDTH-1];
                end
                ModeRotr: begin
                    q_d    = {q_q[0], q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                ModeInc: begin
                    q_d     = q_q + One;
                    carry_d = (q_q == AllOnes);
                end
                ModeDec: begin
                    q_d     = q_q - One;
                    carry_d = (q_q == AllZero);
                end
                // Unknown mode bits hold state rather than propagate X
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q     <= RESET_VAL;
            sout_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            sout_q  <= sout_d;
            carry_q <= carry_d;
        end
    end

    assign q     = q_q;
    assign sout  = sout_q;
    assign carry = carry_q;
    assign zero  = (q_q == AllZero);

endmodule

// File: tb/tb_univ_reg.sv
// Scoreboard bench for univ_reg: four instances (8/8/2/64 bits) share stimulus and are
// checked against an arithmetic reference model, plus directed constant checks.
module tb_univ_reg;

    typedef struct packed {
        logic [3:0][63:0] q;
        logic [3:0]       s;
        logic [3:0]       c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  mode = 3'b000;
    logic [63:0] d = '0;
    logic        sl = 1'b0;
    logic        sr = 1'b0;

    logic [7:0]  q_a, q_b;
    logic [1:0]  q_c;
    logic [63:0] q_e;
    logic        so_a, so_b, so_c, so_e;
    logic        cy_a, cy_b, cy_c, cy_e;
    logic        z_a, z_b, z_c, z_e;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    exp_t        sb[$];

    int unsigned wid[4]  = '{8, 8, 2, 64};
    logic [63:0] rval[4] = '{64'h0, 64'h3C, 64'h2, 64'hDEAD_BEEF_0123_4567};
    logic [63:0] mq[4];
    logic        ms[4];
    logic        mc[4];

    always #5 clk = ~clk;

    univ_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut_a (
        .clk(clk), .reset(rst), .en(en), .mode(mode), .d(d[7:0]), .sin_l(sl), .sin_r(sr),
        .q(q_a), .sout(so_a), .carry(cy_a), .zero(z_a));
    univ_reg #(.WIDTH(8), .RESET_VAL(8'h3C)) dut_b (
        .clk(clk), .reset(rst), .en(en), .mode(mode), .d(d[7:0]), .sin_l(sl), .sin_r(sr),
        .q(q_b), .sout(so_b), .carry(cy_b), .zero(z_b));
    univ_reg #(.WIDTH(2), .RESET_VAL(2'b10)) dut_c (
        .clk(clk), .reset(rst), .en(en), .mode(mode), .d(d[1:0]), .sin_l(sl), .sin_r(sr),
        .q(q_c), .sout(so_c), .carry(cy_c), .zero(z_c));
    univ_reg #(.WIDTH(64), .RESET_VAL(64'hDEAD_BEEF_0123_4567)) dut_e (
        .clk(clk), .reset(rst), .en(en), .mode(mode), .d(d), .sin_l(sl), .sin_r(sr),
        .q(q_e), .sout(so_e), .carry(cy_e), .zero(z_e));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] mask_of(input int unsigned w);
        return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mq[i] = rval[i];
            ms[i] = 1'b0;
            mc[i] = 1'b0;
        end
    endtask

    // Register treated as an unsigned number x in [0, 2^w); every op is arithmetic on x
    task automatic model_op(input logic [2:0] m, input logic [63:0] dv, input logic l,
                            input logic r);
        for (int i = 0; i < 4; i++) begin
            logic [63:0] msk, top, x;
            msk = mask_of(wid[i]);
            top = 64'd1 << (wid[i] - 1);
            x   = mq[i];
            case (m)
                3'd1: begin mq[i] = dv & msk; mc[i] = 1'b0; end
                3'd2: begin ms[i] = (x / top) != 0; mq[i] = (x * 2 + 64'(l)) & msk; end
                3'd3: begin ms[i] = (x % 2) != 0; mq[i] = x / 2 + (r ? top : 64'd0); end
                3'd4: begin ms[i] = (x / top) != 0; mq[i] = ((x * 2) & msk) + x / top; end
                3'd5: begin ms[i] = (x % 2) != 0; mq[i] = x / 2 + (x % 2) * top; end
                3'd6: begin mc[i] = (x == msk); mq[i] = (x + 1) & msk; end
                3'd7: begin mc[i] = (x == 0); mq[i] = (x - 1) & msk; end
                default: ;
            endcase
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.q[i] = mq[i];
            e.s[i] = ms[i];
            e.c[i] = mc[i];
        end
        return e;
    endfunction

    // Monitor: one scoreboard entry per rising clk or reset assertion
    initial begin
        exp_t e;
        logic [63:0] aq;
        logic as, ac, az;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                for (int i = 0; i < 4; i++) begin
                    case (i)
                        0: begin aq = 64'(q_a); as = so_a; ac = cy_a; az = z_a; end
                        1: begin aq = 64'(q_b); as = so_b; ac = cy_b; az = z_b; end
                        2: begin aq = 64'(q_c); as = so_c; ac = cy_c; az = z_c; end
                        default: begin aq = q_e; as = so_e; ac = cy_e; az = z_e; end
                    endcase
                    chk($sformatf("q[%0d]", i), aq, e.q[i]);
                    chk($sformatf("sout[%0d]", i), 64'(as), 64'(e.s[i]));
                    chk($sformatf("carry[%0d]", i), 64'(ac), 64'(e.c[i]));
                    chk($sformatf("zero[%0d]", i), 64'(az), 64'(e.q[i] == 64'd0));
                end
            end
        end
    end

    // Called at a falling edge; inputs are scrambled after the rising edge to prove
    // only edge-time values matter.
    task automatic step(input logic e, input logic [2:0] m, input logic [63:0] dv,
                        input logic l, input logic r);
        en = e; mode = m; d = dv; sl = l; sr = r;
        if (rst) model_reset();
        else if (e) model_op(m, dv, l, r);
        sb.push_back(snap());
        @(posedge clk);
        #2;
        en = 1'($urandom); mode = 3'($urandom); d = {$urandom, $urandom};
        sl = 1'($urandom); sr = 1'($urandom);
        @(negedge clk);
    endtask

    task automatic reset_mid();
        #2;
        model_reset();
        sb.push_back(snap());
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] dv;
        #1;
        model_reset();
        sb.push_back(snap());
        rst = 1'b1;
        sb.push_back(snap());
        @(negedge clk);
        step(1'b1, 3'd6, 64'h0, 1'b1, 1'b1);
        rst = 1'b0;

        step(1'b1, 3'd1, 64'hA5, 1'b0, 1'b0);
        chk("load_q", 64'(q_a), 64'hA5);
        chk("load_carry", 64'(cy_a), 64'd0);
        chk("load_zero", 64'(z_a), 64'd0);
        step(1'b1, 3'd2, 64'h0, 1'b1, 1'b0);
        chk("shl_q", 64'(q_a), 64'h4B);
        chk("shl_sout", 64'(so_a), 64'd1);
        step(1'b1, 3'd3, 64'h0, 1'b1, 1'b0);
        chk("shr_q", 64'(q_a), 64'h25);
        chk("shr_sout", 64'(so_a), 64'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 3'($urandom), {$urandom, $urandom}, 1'b0, 1'b0);
        chk("hold_q", 64'(q_a), 64'h25);
        chk("hold_sout", 64'(so_a), 64'd1);

        step(1'b1, 3'd1, 64'h81, 1'b0, 1'b0);
        step(1'b1, 3'd4, 64'h0, 1'b0, 1'b0);
        chk("rotl1_q", 64'(q_a), 64'h03);
        chk("rotl1_sout", 64'(so_a), 64'd1);
        for (int i = 0; i < 7; i++) step(1'b1, 3'd4, 64'h0, 1'b0, 1'b0);
        chk("rotl8_q", 64'(q_a), 64'h81);

        step(1'b1, 3'd1, 64'hFF, 1'b0, 1'b0);
        step(1'b1, 3'd6, 64'h0, 1'b0, 1'b0);
        chk("inc_wrap_q", 64'(q_a), 64'h00);
        chk("inc_wrap_carry", 64'(cy_a), 64'd1);
        chk("inc_wrap_zero", 64'(z_a), 64'd1);
        step(1'b1, 3'd7, 64'h0, 1'b0, 1'b0);
        chk("dec_wrap_q", 64'(q_a), 64'hFF);
        chk("dec_wrap_carry", 64'(cy_a), 64'd1);
        step(1'b1, 3'd7, 64'h0, 1'b0, 1'b0);
        chk("dec_q", 64'(q_a), 64'hFE);
        chk("dec_carry", 64'(cy_a), 64'd0);

        // Give sout a nonzero value so the reset clear is observable
        step(1'b1, 3'd1, 64'h11, 1'b0, 1'b0);
        step(1'b1, 3'd3, 64'h0, 1'b0, 1'b0);
        step(1'b1, 3'd1, 64'h10, 1'b0, 1'b0);
        step(1'b1, 3'd6, 64'h0, 1'b0, 1'b0);
        step(1'b1, 3'd6, 64'h0, 1'b0, 1'b0);
        chk("count_q", 64'(q_b), 64'h12);
        chk("pre_rst_sout", 64'(so_b), 64'd1);
        reset_mid();
        #2;
        chk("async_rst_q", 64'(q_b), 64'h3C);
        chk("async_rst_carry", 64'(cy_b), 64'd0);
        chk("async_rst_sout", 64'(so_b), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 3'd6, 64'h0, 1'b0, 1'b0);
        chk("rst_clk_q", 64'(q_b), 64'h3C);
        rst = 1'b0;
        step(1'b1, 3'd6, 64'h0, 1'b0, 1'b0);
        chk("post_rst_inc", 64'(q_b), 64'h3D);

        for (int i = 0; i < 800; i++) begin
            if (!rst && $urandom_range(0, 59) == 0) reset_mid();
            case ($urandom_range(0, 3))
                0: dv = '1;
                1: dv = '0;
                default: dv = {$urandom, $urandom};
            endcase
            step($urandom_range(0, 3) != 0, 3'($urandom), dv, 1'($urandom), 1'($urandom));
            if (rst && $urandom_range(0, 1) == 0) rst = 1'b0;
        end
        rst = 1'b0;
        step(1'b0, 3'd0, 64'h0, 1'b0, 1'b0);
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_reg.md
UNIV_REG -- requirements
Module: univ_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port en  input  1  operation enable; sampled on rising clk.
REQ-006 Port mode  input  3  operation select, encoding per REQ-011.
REQ-007 Port d  input  WIDTH  parallel load data.
REQ-008 Port sin_l  input  1  serial input entering bit 0 on shift-left.
REQ-009 Port sin_r  input  1  serial input entering bit WIDTH-1 on shift-right.
REQ-010 Port q  output  WIDTH  register contents; Ports sout, carry  output  1 each, registered flags; Port zero  output  1  combinational flag, high when q == 0.

Function
REQ-011 On rising clk with en=1, q SHALL update per mode: 000 hold; 001 load q<=d; 010 shl q<={q[W-2:0],sin_l}; 011 shr q<={sin_r,q[W-1:1]}; 100 rotl q<={q[W-2:0],q[W-1]}; 101 rotr q<={q[0],q[W-1:1]}; 110 inc q<=q+1; 111 dec q<=q-1.
REQ-012 With en=0, q, sout and carry SHALL hold regardless of mode, d, sin_l, sin_r.
REQ-013 Latency SHALL be one cycle: result visible on q immediately after the enabling edge.
REQ-014 sout SHALL capture the bit leaving the register: q[W-1] before the edge for shl/rotl, q[0] for shr/rotr; sout SHALL hold in all other modes.
REQ-015 carry SHALL be set on inc when q was all-ones (q wraps to 0), on dec when q was 0 (q wraps to all-ones), and cleared on any other inc/dec.
REQ-016 carry SHALL be cleared on load (001); carry SHALL hold on hold, shift and rotate modes.
REQ-017 Arithmetic SHALL be modulo 2^WIDTH; no saturation.
REQ-018 zero SHALL track q combinationally with no extra cycle of latency, including during reset.
REQ-019 All mode encodings are defined; no illegal state and no X propagation from any defined input combination.
REQ-020 Inputs SHALL be sampled only at the rising clk edge; changes between edges SHALL not affect q, sout or carry.

Reset
REQ-021 Assertion of reset SHALL immediately, without a clock edge, force q=RESET_VAL, sout=0, carry=0.
REQ-022 While reset is high, clk edges and all other inputs SHALL have no effect.
REQ-023 Reset asserted mid-sequence (e.g. during a run of shifts or counts) SHALL abort it; no partial result SHALL survive.
REQ-024 After reset deasserts, the first rising clk edge with en=1 SHALL execute the selected mode normally.

Verification (WIDTH=8, RESET_VAL=0 unless stated)
REQ-025 Reset then load: reset pulse; en=1, mode=001, d=8'hA5, one edge -> q=8'hA5, carry=0, zero=0.
REQ-026 Shift/serial: q=8'hA5; shl with sin_l=1 -> q=8'h4B, sout=1; shr with sin_r=0 -> q=8'h25, sout=1; en=0 then 3 edges -> q=8'h25, sout=1 unchanged.
REQ-027 Rotate round trip: q=8'h81; 8 rotl edges -> q=8'h81; intermediate after 1 edge q=8'h03, sout=1.
REQ-028 Wrap-around: q=8'hFF, inc -> q=8'h00, carry=1, zero=1; dec -> q=8'hFF, carry=1; dec -> q=8'hFE, carry=0.
REQ-029 Async reset mid-operation: RESET_VAL=8'h3C; inc running from 8'h10; assert reset between edges -> q=8'h3C, carry=0, sout=0 before next edge; clk toggling during reset leaves q=8'h3C.
REQ-030 Mode sweep: all 8 modes with random d/sin values against a reference model for WIDTH=2 and WIDTH=64; zero matches (q==0) every cycle.
